// File: rtl/div_iter_if.sv
// Request/result bundle between the EXE-stage multiply/divide controller (master)
// and the iterative divider (slave).
interface div_iter_if;
  logic        div_start;
  logic        div_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        flush;
  logic        div_busy;
  logic        div_finish;
  logic [31:0] quotient;
  logic [31:0] remainder;

  modport master (
    output div_start, div_signed, dividend, divisor, flush,
    input  div_busy, div_finish, quotient, remainder
  );

  modport slave (
    input  div_start, div_signed, dividend, divisor, flush,
    output div_busy, div_finish, quotient, remainder
  );
endinterface

// File: rtl/div_iter.sv
// Iterative restoring radix-2 divider, 32 steps plus sign fix-up (35-cycle latency).
// Optional DIV_EARLY_EXIT_EN: finish in two cycles when |dividend| < |divisor|.
module div_iter (
  input  logic       clk,
  input  logic       rst,
  div_iter_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, INIT, ITER, FIX, DONE} state_t;

  state_t      state, state_next;
  logic [31:0] a_reg, b_reg;
  logic        sgn_reg;
  logic [31:0] q_work, d_mag;
  logic [32:0] rem_work;
  logic [4:0]  cnt;
  logic        q_neg, r_neg;
  logic [31:0] quot_q, rem_q;
  logic        busy, finish;
  logic        accept, div_zero, early;
  logic [31:0] a_mag, b_mag;
  logic [33:0] shifted, diff;

  assign accept   = bus.div_start && !bus.flush && (state == IDLE || state == DONE);
  assign a_mag    = (sgn_reg && a_reg[31]) ? (~a_reg + 32'd1) : a_reg;
  assign b_mag    = (sgn_reg && b_reg[31]) ? (~b_reg + 32'd1) : b_reg;
  assign div_zero = (b_reg == 32'd0);

`ifdef DIV_EARLY_EXIT_EN
  assign early = !div_zero && (a_mag < b_mag);
`else
  assign early = 1'b0;
`endif

  // Partial remainder is always below the divisor, so its top bit stays clear.
  assign shifted = {rem_work, q_work[31]};
  assign diff    = shifted - {2'b00, d_mag};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: if (accept) state_next = INIT;
      INIT: begin
        busy       = 1'b1;
        state_next = (div_zero || early) ? DONE : ITER;
      end
      ITER: begin
        busy = 1'b1;
        if (cnt == 5'd31) state_next = FIX;
      end
      FIX: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        finish     = 1'b1;
        state_next = accept ? INIT : IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (bus.flush) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg    <= 32'd0;
      b_reg    <= 32'd0;
      sgn_reg  <= 1'b0;
      q_work   <= 32'd0;
      d_mag    <= 32'd0;
      rem_work <= 33'd0;
      cnt      <= 5'd0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      quot_q   <= 32'd0;
      rem_q    <= 32'd0;
    end else begin
      if (accept) begin
        a_reg   <= bus.dividend;
        b_reg   <= bus.divisor;
        sgn_reg <= bus.div_signed;
      end
      // A flush in any state must leave the visible results untouched.
      if (!bus.flush) begin
        case (state)
          INIT: begin
            cnt      <= 5'd0;
            rem_work <= 33'd0;
            q_work   <= a_mag;
            d_mag    <= b_mag;
            q_neg    <= sgn_reg && (a_reg[31] ^ b_reg[31]);
            r_neg    <= sgn_reg && a_reg[31];
            if (div_zero) begin
              quot_q <= 32'hFFFF_FFFF;
              rem_q  <= a_reg;
            end else if (early) begin
              quot_q <= 32'd0;
              rem_q  <= a_reg;
            end
          end
          ITER: begin
            cnt <= cnt + 5'd1;
            if (!diff[33]) begin
              rem_work <= diff[32:0];
              q_work   <= {q_work[30:0], 1'b1};
            end else begin
              rem_work <= shifted[32:0];
              q_work   <= {q_work[30:0], 1'b0};
            end
          end
          FIX: begin
            quot_q <= q_neg ? (~q_work + 32'd1) : q_work;
            rem_q  <= r_neg ? (~rem_work[31:0] + 32'd1) : rem_work[31:0];
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.div_busy   = busy;
  assign bus.div_finish = finish;
  assign bus.quotient   = quot_q;
  assign bus.remainder  = rem_q;

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: expected results queued at start, compared at div_finish.
// Latency expectations follow DIV_EARLY_EXIT_EN when it is defined.
module tb_div_iter;

  logic clk = 1'b0;
  logic rst;

  div_iter_if bus ();

  div_iter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic [31:0] lat;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] last_q   = 32'd0;
  logic [31:0] last_r   = 32'd0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mag(input bit s, input logic [31:0] x);
    return (s && x[31]) ? (~x + 32'd1) : x;
  endfunction

  function automatic logic [31:0] latency(input bit s, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 32'd2;
`ifdef DIV_EARLY_EXIT_EN
    if (mag(s, a) < mag(s, b)) return 32'd2;
`endif
    return 32'd35;
  endfunction

  // Reference divide for general operands; the special cases use spec constants instead.
  function automatic exp_t model(input bit s, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    if (s) begin
      e.q = $signed(a) / $signed(b);
      e.r = $signed(a) % $signed(b);
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    e.lat = latency(s, a, b);
    return e;
  endfunction

  task automatic applyStimulus(input bit s, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] q, input logic [31:0] r, input bit push);
    exp_t e;
    @(negedge clk);
    bus.div_start  = 1'b1;
    bus.div_signed = s;
    bus.dividend   = a;
    bus.divisor    = b;
    e.q   = q;
    e.r   = r;
    e.lat = latency(s, a, b);
    if (push) sb.push_back(e);
    @(posedge clk);
    #1;
    bus.div_start = 1'b0;
  endtask

  task automatic waitResult(input string tag);
    exp_t e;
    int   cyc  = 0;
    bit   seen = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      cyc = c;
      if (c == 1) checkOutput({tag, " busy_in_init"}, {31'd0, bus.div_busy}, 32'd1);
      if (bus.div_finish) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (sb.size() == 0) begin
      n_checks++;
      $error("[TB] FAIL %s: scoreboard empty at finish", tag);
      return;
    end
    e = sb.pop_front();
    checkOutput({tag, " finish_cycle"}, seen ? 32'(cyc) : 32'd0, e.lat);
    if (seen) begin
      checkOutput({tag, " quotient"},  bus.quotient,  e.q);
      checkOutput({tag, " remainder"}, bus.remainder, e.r);
      checkOutput({tag, " busy_in_done"}, {31'd0, bus.div_busy}, 32'd0);
    end
    last_q = e.q;
    last_r = e.r;
  endtask

  typedef struct packed {
    bit          s;
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  initial begin
    op_t  ops[6];
    exp_t e;
    bit   seen;
    logic [31:0] ra, rb;

    rst            = 1'b1;
    bus.div_start  = 1'b0;
    bus.div_signed = 1'b0;
    bus.dividend   = 32'd0;
    bus.divisor    = 32'd0;
    bus.flush      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset quotient",  bus.quotient,  32'd0);
    checkOutput("reset remainder", bus.remainder, 32'd0);
    checkOutput("reset busy",   {31'd0, bus.div_busy},   32'd0);
    checkOutput("reset finish", {31'd0, bus.div_finish}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b1);
    waitResult("udiv 100/7");
    @(posedge clk);
    #1;
    checkOutput("finish one-shot", {31'd0, bus.div_finish}, 32'd0);
    checkOutput("idle after done", {31'd0, bus.div_busy},   32'd0);

    applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b1);
    waitResult("sdiv -7/2");
    applyStimulus(1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
    waitResult("div by zero");
    applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b1);
    waitResult("signed overflow");
    applyStimulus(1'b0, 32'd3, 32'd10, 32'd0, 32'd3, 1'b1);
    waitResult("udiv 3/10");

    ops[0] = '{1'b1, 32'd100,        32'hFFFF_FFF9};
    ops[1] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9};
    ops[2] = '{1'b0, 32'hFFFF_FFFF,  32'd1};
    ops[3] = '{1'b0, 32'h8000_0000,  32'd3};
    ops[4] = '{1'b1, 32'd5,          32'hFFFF_FFFE};
    ops[5] = '{1'b1, 32'hFFFF_FFFD,  32'd7};
    foreach (ops[i]) begin
      e = model(ops[i].s, ops[i].a, ops[i].b);
      applyStimulus(ops[i].s, ops[i].a, ops[i].b, e.q, e.r, 1'b1);
      waitResult($sformatf("table op %0d", i));
    end
    for (int i = 0; i < 3; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 28);
      if (rb == 32'd0) rb = 32'd1;
      e = model(1'b0, ra, rb);
      applyStimulus(1'b0, ra, rb, e.q, e.r, 1'b1);
      waitResult($sformatf("random op %0d", i));
    end

    // Flush during the 10th ITER cycle: abort without a result.
    applyStimulus(1'b0, 32'd1000, 32'd3, 32'd0, 32'd0, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    checkOutput("flush idle busy",     {31'd0, bus.div_busy}, 32'd0);
    checkOutput("flush kept quotient",  bus.quotient,  last_q);
    checkOutput("flush kept remainder", bus.remainder, last_r);
    seen = 1'b0;
    repeat (5) begin
      if (bus.div_finish || bus.div_busy) seen = 1'b1;
      @(posedge clk);
      #1;
    end
    checkOutput("flush no finish", {31'd0, seen}, 32'd0);
    applyStimulus(1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b1);
    waitResult("after flush 1000/3");

    // Reset mid-ITER with a competing start.
    applyStimulus(1'b0, 32'hDEAD_BEEF, 32'd5, 32'd0, 32'd0, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst            = 1'b1;
    bus.div_start  = 1'b1;
    bus.dividend   = 32'd50;
    bus.divisor    = 32'd5;
    @(posedge clk);
    #1;
    checkOutput("mid reset quotient",  bus.quotient,  32'd0);
    checkOutput("mid reset remainder", bus.remainder, 32'd0);
    checkOutput("mid reset busy",   {31'd0, bus.div_busy},   32'd0);
    checkOutput("mid reset finish", {31'd0, bus.div_finish}, 32'd0);
    @(negedge clk);
    rst           = 1'b0;
    bus.div_start = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (bus.div_finish || bus.div_busy) seen = 1'b1;
    end
    checkOutput("start ignored in reset", {31'd0, seen}, 32'd0);
    applyStimulus(1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b1);
    waitResult("after reset 50/5");

    checkOutput("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/div_iter.md
DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 The block SHALL have these ports: clk, input, 1, the single clock; all state changes on the rising edge.
REQ-002 The block SHALL have rst, input, 1: synchronous, active-high reset.
REQ-003 The block SHALL have div_start, input, 1: division request from the EXE-stage multiply/divide controller.
REQ-004 The block SHALL have div_signed, input, 1: 1 = DIV (signed), 0 = DIVU; sampled with div_start.
REQ-005 The block SHALL have dividend, input, 32: BusA operand; sampled with div_start.
REQ-006 The block SHALL have divisor, input, 32: BusB operand; sampled with div_start.
REQ-007 The block SHALL have flush, input, 1: exception/pipeline flush that aborts the operation.
REQ-008 The block SHALL have div_busy, output, 1: high in INIT, ITER and FIX.
REQ-009 The block SHALL have div_finish, output, 1: single-cycle pulse; high only in DONE.
REQ-010 The block SHALL have quotient, output, 32: to LO.
REQ-011 The block SHALL have remainder, output, 32: to HI.

Function
REQ-012 The state machine SHALL have the states IDLE, INIT, ITER, FIX and DONE, each held in a register.
REQ-013 Acceptance: div_start=1, flush=0, state IDLE or DONE; operands latched; next state INIT; div_start in any other state ignored.
REQ-014 INIT SHALL compute operand magnitudes (two's-complement abs when div_signed=1, raw otherwise), record quotient sign (operand signs differ) and remainder sign (dividend sign), clear the iteration counter, then go to ITER.
REQ-015 ITER SHALL perform one restoring radix-2 step per cycle on a 33-bit partial remainder, with exactly 32 cycles counted by a 5-bit counter; ITER exits to FIX when the counter equals 31.
REQ-016 FIX SHALL negate the quotient/remainder per the recorded signs, load the quotient/remainder registers, and then go to DONE.
REQ-017 DONE SHALL assert div_finish for exactly one cycle, then go to IDLE, unless a new start is accepted in that cycle.
REQ-018 Latency: with acceptance at edge k, div_finish SHALL be high in the cycle after edge k+34 (35th cycle); back-to-back acceptance in DONE SHALL be legal.
REQ-019 Divide-by-zero: INIT SHALL go directly to DONE with quotient=32'hFFFF_FFFF and remainder=dividend, giving div_finish in the 2nd cycle after acceptance.
REQ-020 Signed overflow 32'h8000_0000 / 32'hFFFF_FFFF SHALL give quotient 32'h8000_0000 and remainder 0 (natural 32-bit wrap, no exception).
REQ-021 The quotient and remainder outputs SHALL change only on the FIX->DONE load or the divide-by-zero/early-exit load, and SHALL otherwise hold their values until the next load.
REQ-022 flush=1 SHALL force IDLE on the next edge from any state, with no div_finish and outputs unchanged; flush SHALL have priority over div_start in the same cycle.
REQ-023 div_busy SHALL be combinational from the state register only.

Reset
REQ-024 rst=1 SHALL force state IDLE, div_busy=0, div_finish=0, quotient=0, remainder=0 and counter=0 on the next edge, including mid-ITER; rst SHALL have priority over flush and div_start.

Configuration
REQ-025 With DIV_EARLY_EXIT_EN defined, INIT SHALL detect |dividend| < |divisor| (divisor non-zero) and go directly to DONE with quotient=0 and remainder=dividend (unmodified, sign preserved), giving div_finish in the 2nd cycle after acceptance.
REQ-026 Without DIV_EARLY_EXIT_EN, all non-zero-divisor operations SHALL take the full 35-cycle path.

Verification
REQ-027 The bench SHALL check: unsigned 100/7, start at edge k -> div_finish high only in the cycle after edge k+34, quotient=14, remainder=2, div_busy low in DONE.
REQ-028 The bench SHALL check: signed -7/2 (32'hFFFF_FFF9, 2) -> quotient=32'hFFFF_FFFD, remainder=32'hFFFF_FFFF.
REQ-029 The bench SHALL check: divisor=0, dividend=32'h1234_5678 -> finish 2 cycles after acceptance, quotient=32'hFFFF_FFFF, remainder=32'h1234_5678.
REQ-030 The bench SHALL check: flush asserted at the 10th ITER cycle -> IDLE next cycle, no div_finish pulse, previous quotient/remainder retained; a new start then completes correctly.
REQ-031 The bench SHALL check: rst asserted mid-ITER -> all outputs 0 on the next edge; with div_start high in the same cycle, the start is ignored.
REQ-032 The bench SHALL check: 3/10 unsigned -> with DIV_EARLY_EXIT_EN, finish in the 2nd cycle with quotient=0 and remainder=3; without the macro, finish in the 35th cycle with the same results.
